// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer. Drives an external saturating countdown
// timer (load/decrement) and decodes one-hot lamp drives for main and side roads.
module traffic_phase_controller #(
  parameter int BIT_WIDTH    = 7,
  parameter int T_MAIN_GREEN = 60,
  parameter int T_YELLOW     = 5,
  parameter int T_ALL_RED    = 2,
  parameter int T_SIDE_GREEN = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 side_sensor,
  input  logic                 tmr_zero,
  output logic                 tmr_down,
  output logic [BIT_WIDTH-1:0] tmr_load_val,
  output logic [2:0]           main_light,
  output logic [2:0]           side_light,
  output logic [2:0]           phase,
  output logic                 side_req
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_t;

  localparam logic [BIT_WIDTH-1:0] DUR_MAIN_GREEN = BIT_WIDTH'(T_MAIN_GREEN);
  localparam logic [BIT_WIDTH-1:0] DUR_YELLOW     = BIT_WIDTH'(T_YELLOW);
  localparam logic [BIT_WIDTH-1:0] DUR_ALL_RED    = BIT_WIDTH'(T_ALL_RED);
  localparam logic [BIT_WIDTH-1:0] DUR_SIDE_GREEN = BIT_WIDTH'(T_SIDE_GREEN);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Held as plain bits so the two unused codes stay representable and recoverable.
  logic [2:0] state_q;
  logic       load_q;
  logic       req_q;

  logic [2:0] next_state;
  logic       legal;
  logic       advance;

  always_comb begin
    next_state = 3'(MAIN_GREEN);
    legal      = 1'b1;
    case (state_q)
      MAIN_GREEN:  next_state = 3'(MAIN_YELLOW);
      MAIN_YELLOW: next_state = 3'(ALL_RED_A);
      ALL_RED_A:   next_state = 3'(SIDE_GREEN);
      SIDE_GREEN:  next_state = 3'(SIDE_YELLOW);
      SIDE_YELLOW: next_state = 3'(ALL_RED_B);
      ALL_RED_B:   next_state = 3'(MAIN_GREEN);
      default:     legal      = 1'b0;
    endcase
  end

  // Main green additionally waits for a latched side-street request.
  assign advance = !load_q && tmr_zero &&
                   ((state_q != 3'(MAIN_GREEN)) || req_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 3'(MAIN_GREEN);
      load_q  <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (!legal) begin
        state_q <= 3'(MAIN_GREEN);
        load_q  <= 1'b1;
      end else if (advance) begin
        state_q <= next_state;
        load_q  <= 1'b1;
      end
      // Clear at the end of the side-green load cycle takes priority over set.
      if ((state_q == 3'(SIDE_GREEN)) && load_q) begin
        req_q <= 1'b0;
      end else if (side_sensor && (state_q != 3'(SIDE_GREEN))) begin
        req_q <= 1'b1;
      end
    end
  end

  always_comb begin
    main_light   = LAMP_RED;
    side_light   = LAMP_RED;
    tmr_load_val = DUR_MAIN_GREEN;
    case (state_q)
      MAIN_GREEN: begin
        main_light   = LAMP_GREEN;
        tmr_load_val = DUR_MAIN_GREEN;
      end
      MAIN_YELLOW: begin
        main_light   = LAMP_YELLOW;
        tmr_load_val = DUR_YELLOW;
      end
      ALL_RED_A:   tmr_load_val = DUR_ALL_RED;
      SIDE_GREEN: begin
        side_light   = LAMP_GREEN;
        tmr_load_val = DUR_SIDE_GREEN;
      end
      SIDE_YELLOW: begin
        side_light   = LAMP_YELLOW;
        tmr_load_val = DUR_YELLOW;
      end
      ALL_RED_B:   tmr_load_val = DUR_ALL_RED;
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase
  end

  assign tmr_down = ~load_q;
  assign phase    = state_q;
  assign side_req = req_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller with a saturating countdown timer attached and
// a phase/age model of the intersection that is compared against the DUT every cycle.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_sensor = 1'b0;
  logic       tmr_zero;
  logic       tmr_down;
  logic [6:0] tmr_load_val;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;
  logic       side_req;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  traffic_phase_controller #(
    .BIT_WIDTH(7), .T_MAIN_GREEN(4), .T_YELLOW(2), .T_ALL_RED(1), .T_SIDE_GREEN(3)
  ) dut (
    .clk(clk), .rst(rst), .side_sensor(side_sensor), .tmr_zero(tmr_zero),
    .tmr_down(tmr_down), .tmr_load_val(tmr_load_val), .main_light(main_light),
    .side_light(side_light), .phase(phase), .side_req(side_req)
  );

  // Clock and downstream timer
  always #5 clk = ~clk;

  logic [6:0] tval = 7'd0;
  always @(posedge clk) begin
    if (!tmr_down) tval <= tmr_load_val;
    else if (tval != 7'd0) tval <= tval - 7'd1;
  end
  assign tmr_zero = (tval == 7'd0);

  // Behavioural model: a phase lasts its duration plus two cycles, main green also
  // needs a pending request; age 0 is the load cycle of the phase.
  int m_phase = 0;
  int m_age = 0;
  bit m_req = 1'b0;

  function automatic int dur(input int p);
    case (p)
      0: return 4;
      1: return 2;
      2: return 1;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int p);
    if (p == 0) return 3'b001;
    if (p == 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int p);
    if (p == 3) return 3'b001;
    if (p == 4) return 3'b010;
    return 3'b100;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_age   = 0;
      m_req   = 1'b0;
    end else begin
      bit nreq;
      nreq = m_req;
      if (side_sensor && m_phase != 3) nreq = 1'b1;
      if (m_phase == 3 && m_age == 0) nreq = 1'b0;
      if (m_phase > 5) begin
        m_phase = 0;
        m_age   = 0;
      end else if (m_age >= dur(m_phase) + 1 && (m_phase != 0 || m_req)) begin
        m_phase = (m_phase + 1) % 6;
        m_age   = 0;
      end else if (m_age < 1000) begin
        m_age = m_age + 1;
      end
      m_req = nreq;
    end
  end

  // Cycle index since the last reset edge, plus a log of what the DUT showed.
  int cyc = 0;
  int log_phase[256];
  int log_down[256];
  int log_req[256];
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end
  always @(negedge clk) begin
    if (cyc < 256) begin
      log_phase[cyc] = int'(phase);
      log_down[cyc]  = int'(tmr_down);
      log_req[cyc]   = int'(side_req);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model plus lamp safety invariants
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", int'(phase), m_phase);
      check("main_light", int'(main_light), int'(exp_main(m_phase)));
      check("side_light", int'(side_light), int'(exp_side(m_phase)));
      check("tmr_down", int'(tmr_down), (m_age != 0) ? 1 : 0);
      check("side_req", int'(side_req), int'(m_req));
      if (m_phase <= 5) check("tmr_load_val", int'(tmr_load_val), dur(m_phase));
      check("main_onehot", $countones(main_light), 1);
      check("side_onehot", $countones(side_light), 1);
      check("one_road_red", int'(main_light[2] | side_light[2]), 1);
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 2000 && cyc != n; k++) begin
      @(posedge clk); #1;
    end
    check("wait_budget", cyc, n);
  endtask

  task automatic pulse_at(input int n);
    wait_cyc(n);
    side_sensor = 1'b1;
    @(posedge clk); #1;
    side_sensor = 1'b0;
  endtask

  initial begin
    int n;

    // 1: no requests, main green held; load only in cycle 0
    do_reset();
    @(negedge clk);
    check("rst_phase", int'(phase), 0);
    check("rst_main", int'(main_light), 3'b001);
    check("rst_side", int'(side_light), 3'b100);
    check("rst_down", int'(tmr_down), 0);
    check("rst_load_val", int'(tmr_load_val), 4);
    check("rst_req", int'(side_req), 0);
    wait_cyc(51);
    n = 0;
    for (int i = 0; i < 50; i++) if (log_phase[i] != 0) n++;
    check("t1_not_main_green", n, 0);
    n = 0;
    for (int i = 0; i < 50; i++) if (log_down[i] == 0) n++;
    check("t1_load_cycles", n, 1);
    check("t1_load_first", log_down[0], 0);
    n = 0;
    for (int i = 0; i < 50; i++) if (log_req[i] != 0) n++;
    check("t1_req_cycles", n, 0);

    // 2: pulse at cycle 2 -> full sequence with hand-computed entry cycles
    do_reset();
    pulse_at(2);
    wait_cyc(30);
    check("t2_mg_last", log_phase[5], 0);
    check("t2_my_first", log_phase[6], 1);
    check("t2_my_last", log_phase[9], 1);
    check("t2_ara_first", log_phase[10], 2);
    check("t2_ara_last", log_phase[12], 2);
    check("t2_sg_first", log_phase[13], 3);
    check("t2_sg_last", log_phase[17], 3);
    check("t2_sy_first", log_phase[18], 4);
    check("t2_sy_last", log_phase[21], 4);
    check("t2_arb_first", log_phase[22], 5);
    check("t2_arb_last", log_phase[24], 5);
    check("t2_mg_again", log_phase[25], 0);

    // 3: late request, timer already at zero -> only the request gate delays
    do_reset();
    pulse_at(20);
    wait_cyc(25);
    check("t3_mg_hold", log_phase[21], 0);
    check("t3_my_entry", log_phase[22], 1);

    // 4: sensor held high -> 25-cycle period, request cleared during side green
    do_reset();
    side_sensor = 1'b1;
    wait_cyc(60);
    side_sensor = 1'b0;
    check("t4_mg_last", log_phase[5], 0);
    check("t4_my_first", log_phase[6], 1);
    check("t4_req_sg_load", log_req[13], 1);
    check("t4_req_cleared", log_req[14], 0);
    check("t4_req_arb", log_req[22], 1);
    check("t4_mg2_last", log_phase[30], 0);
    check("t4_my2_first", log_phase[31], 1);
    check("t4_mg3_last", log_phase[55], 0);
    check("t4_my3_first", log_phase[56], 1);

    // 5: reset mid side green, and reset with a pending request
    do_reset();
    pulse_at(2);
    wait_cyc(15);
    check("t5_in_sg", int'(phase), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_main", int'(main_light), 3'b001);
    check("t5_load_val", int'(tmr_load_val), 4);
    check("t5_down", int'(tmr_down), 0);
    check("t5_req", int'(side_req), 0);
    pulse_at(0);
    wait_cyc(3);
    check("t5b_req_set", int'(side_req), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5b_req_after_rst", int'(side_req), 0);

    // 6: illegal code deposited mid main green
    do_reset();
    wait_cyc(3);
    dut.state_q = 3'd6;
    m_phase = 6;
    @(negedge clk);
    check("t6_phase_illegal", int'(phase), 6);
    check("t6_main_red", int'(main_light), 3'b100);
    check("t6_side_red", int'(side_light), 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_recover_phase", int'(phase), 0);
    check("t6_recover_down", int'(tmr_down), 0);
    check("t6_recover_load_val", int'(tmr_load_val), 4);
    repeat (10) @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
